// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-search cluster: sequencer states and the
// RAM-owner mode encodings used by both the key sequencer and the RAM controller.
package rc4_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_INIT_GAP,
    ST_SHUF,
    ST_SHUF_GAP,
    ST_DEC,
    ST_DEC_GAP,
    ST_FOUND,
    ST_EXHAUSTED
  } seq_state_t;

  localparam logic [5:0] MODE_IDLE = 6'b000_000;
  localparam logic [5:0] MODE_INIT = 6'b001_000;
  localparam logic [5:0] MODE_SHUF = 6'b010_000;
  localparam logic [5:0] MODE_DEC  = 6'b011_000;

  // RAM owner for a given sequencer state; every non-phase state releases the RAM.
  function automatic logic [5:0] mode_of(input seq_state_t s);
    case (s)
      ST_INIT: return MODE_INIT;
      ST_SHUF: return MODE_SHUF;
      ST_DEC:  return MODE_DEC;
      default: return MODE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/key_sequencer.sv
// Key sequencer: walks candidate keys through init / shuffle / decrypt phases
// of the RC4 engine, stopping on a successful decrypt, key exhaustion or abort.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | waiting for start, RAM released
// ST_INIT      | initializer owns RAM, waiting for finish_bus[0]
// ST_INIT_GAP  | RAM released until finish_bus clears
// ST_SHUF      | shuffler owns RAM, waiting for finish_bus[1]
// ST_SHUF_GAP  | RAM released until finish_bus clears
// ST_DEC       | decryptor owns RAM, waiting for finish_bus[2]
// ST_DEC_GAP   | RAM released; then found / exhausted / next key
// ST_FOUND     | key holds the winning value; start restarts the search
// ST_EXHAUSTED | no key up to KEY_MAX worked; start restarts the search
module key_sequencer
  import rc4_pkg::*;
#(
  parameter int          RAM_WIDTH   = 8,
  parameter int          KEY_LENGTH  = 3,
  parameter int          NUM_DEVICES = 3,
  parameter int unsigned KEY_START   = 0,
  parameter int unsigned KEY_STEP    = 1,
  parameter int unsigned KEY_MAX     = 24'h3FFFFF
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic                                    abort,
  input  logic [NUM_DEVICES-1:0]                  finish_bus,
  input  logic                                    success,
  output logic [5:0]                              mode,
  output logic [0:KEY_LENGTH-1][RAM_WIDTH-1:0]    key,
  output logic                                    busy,
  output logic                                    found,
  output logic                                    exhausted,
  output logic [KEY_LENGTH*RAM_WIDTH-1:0]         attempts
);

  localparam int KW = KEY_LENGTH * RAM_WIDTH;

  localparam logic [KW-1:0] START_V = KW'(KEY_START);
  // Key advance is compared one bit wider so a step past all-ones never wraps.
  localparam logic [KW:0]   STEP_X  = (KW+1)'(KEY_STEP);
  localparam logic [KW:0]   MAX_X   = (KW+1)'(KEY_MAX);

  seq_state_t    state_q, state_d;
  logic [KW-1:0] key_q, key_d;
  logic [KW-1:0] att_q, att_d;
  logic          succ_q, succ_d;
  logic [5:0]    mode_q;
  logic [KW:0]   key_next_x;

  assign key_next_x = {1'b0, key_q} + STEP_X;

  assign busy      = (state_q != ST_IDLE) && (state_q != ST_FOUND) &&
                     (state_q != ST_EXHAUSTED);
  assign found     = (state_q == ST_FOUND);
  assign exhausted = (state_q == ST_EXHAUSTED);
  assign mode      = mode_q;
  assign key       = key_q;
  assign attempts  = att_q;

  // State and datapath registers; mode is decoded from the next state so it is
  // glitch-free and lands on the same edge as the state change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_IDLE;
      key_q   <= START_V;
      att_q   <= '0;
      succ_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_of(state_d);
      key_q   <= key_d;
      att_q   <= att_d;
      succ_q  <= succ_d;
    end
  end

  // Next-state, key advance, attempt counting and verdict capture.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    att_d   = att_q;
    succ_d  = succ_q;
    case (state_q)
      ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
        if (start && !abort) begin
          state_d = ST_INIT;
          key_d   = START_V;
          att_d   = '0;
          succ_d  = 1'b0;
        end
      end
      ST_INIT:     if (finish_bus[0])     state_d = ST_INIT_GAP;
      ST_INIT_GAP: if (finish_bus == '0)  state_d = ST_SHUF;
      ST_SHUF:     if (finish_bus[1])     state_d = ST_SHUF_GAP;
      ST_SHUF_GAP: if (finish_bus == '0)  state_d = ST_DEC;
      ST_DEC: begin
        if (finish_bus[2]) begin
          state_d = ST_DEC_GAP;
          succ_d  = success;
          if (att_q != '1) att_d = att_q + KW'(1);
        end
      end
      ST_DEC_GAP: begin
        if (finish_bus == '0) begin
          if (succ_q) begin
            state_d = ST_FOUND;
          end else if (key_next_x > MAX_X) begin
            state_d = ST_EXHAUSTED;
          end else begin
            key_d   = key_next_x[KW-1:0];
            state_d = ST_INIT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort freezes key and attempts where they stand, even on a phase-exit edge.
    if (abort && busy) begin
      state_d = ST_IDLE;
      key_d   = key_q;
      att_d   = att_q;
    end
  end

endmodule

// File: tb/tb_key_sequencer.sv
// Bench for key_sequencer: a randomized RC4-engine responder drives the
// finish/success handshake; expected outcomes come from key-range arithmetic.
module tb_key_sequencer;
  import rc4_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, abort, success;
  logic [2:0]  finish_bus;
  int          sel;
  int          checks = 0;
  int          errors = 0;

  logic        st0, st1, st2, ab0, ab1, ab2;
  logic [2:0]  fb0, fb1, fb2;
  logic [5:0]  mode0, mode1, mode2;
  logic [0:2][7:0] key0, key1, key2;
  logic        busy0, busy1, busy2, fnd0, fnd1, fnd2, exh0, exh1, exh2;
  logic [23:0] att0, att1, att2;

  logic [5:0]  mode_s;
  logic [23:0] key_s, att_s;
  logic        busy_s, found_s, exh_s;

  always #5 clk = ~clk;

  assign st0 = start && (sel == 0);
  assign st1 = start && (sel == 1);
  assign st2 = start && (sel == 2);
  assign ab0 = abort && (sel == 0);
  assign ab1 = abort && (sel == 1);
  assign ab2 = abort && (sel == 2);
  assign fb0 = (sel == 0) ? finish_bus : 3'b000;
  assign fb1 = (sel == 1) ? finish_bus : 3'b000;
  assign fb2 = (sel == 2) ? finish_bus : 3'b000;

  key_sequencer u_dut0 (
    .clk(clk), .reset(reset), .start(st0), .abort(ab0), .finish_bus(fb0),
    .success(success), .mode(mode0), .key(key0), .busy(busy0), .found(fnd0),
    .exhausted(exh0), .attempts(att0)
  );

  key_sequencer #(.KEY_START(24'h3FFFFE)) u_dut1 (
    .clk(clk), .reset(reset), .start(st1), .abort(ab1), .finish_bus(fb1),
    .success(success), .mode(mode1), .key(key1), .busy(busy1), .found(fnd1),
    .exhausted(exh1), .attempts(att1)
  );

  key_sequencer #(.KEY_START(1), .KEY_STEP(3), .KEY_MAX(10)) u_dut2 (
    .clk(clk), .reset(reset), .start(st2), .abort(ab2), .finish_bus(fb2),
    .success(success), .mode(mode2), .key(key2), .busy(busy2), .found(fnd2),
    .exhausted(exh2), .attempts(att2)
  );

  always_comb begin
    mode_s = mode0; key_s = key0; att_s = att0;
    busy_s = busy0; found_s = fnd0; exh_s = exh0;
    case (sel)
      1: begin mode_s = mode1; key_s = key1; att_s = att1;
               busy_s = busy1; found_s = fnd1; exh_s = exh1; end
      2: begin mode_s = mode2; key_s = key2; att_s = att2;
               busy_s = busy2; found_s = fnd2; exh_s = exh2; end
      default: ;
    endcase
  end

  function automatic longint start_of(input int s);
    case (s)
      1: return 64'h3FFFFE;
      2: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic longint step_of(input int s);
    return (s == 2) ? 3 : 1;
  endfunction

  function automatic longint max_of(input int s);
    return (s == 2) ? 10 : 64'h3FFFFF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs one search on DUT s. The responder finishes each phase after a random
  // (or fixed long) latency and holds finish_bus in the gap for hold cycles.
  // With stop_att >= 0 the run stops as soon as mode==stop_mode with that
  // attempt count, leaving the DUT mid-search.
  task automatic run_search(input int s, input longint target, input bit slow,
                            input int hold_fix, input logic [5:0] stop_mode,
                            input int stop_att, input string tag,
                            output int first_gap);
    int lat, hold, hold_set, gap_len, idx, n_init, b;
    int seq_err, key_err, gap_err;
    bit gap_valid, done, stopped, exp_found;
    longint st, stp, mx, exp_key, exp_att;
    logic [5:0] cur, prev;
    logic [2:0] fb;
    logic [5:0] pattern [6];
    pattern = '{MODE_INIT, MODE_IDLE, MODE_SHUF, MODE_IDLE, MODE_DEC, MODE_IDLE};
    lat = 0; hold = 0; hold_set = 0; gap_len = 0; idx = 0; n_init = 0;
    seq_err = 0; key_err = 0; gap_err = 0; gap_valid = 0; first_gap = -1;
    done = 0; stopped = 0;
    st = start_of(s); stp = step_of(s); mx = max_of(s);
    if (target >= st && target <= mx && ((target - st) % stp) == 0) begin
      exp_found = 1; exp_att = (target - st) / stp + 1; exp_key = target;
    end else begin
      exp_found = 0; exp_att = (mx - st) / stp + 1; exp_key = st + (exp_att - 1) * stp;
    end

    sel = s; finish_bus = '0; success = 1'b0; abort = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, "_start_lat"}, 32'(mode_s), 32'(MODE_INIT));
    check({tag, "_flags_clr"}, {29'd0, found_s, exh_s, busy_s}, 32'd1);
    prev = MODE_IDLE;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      cur = mode_s;
      if (stop_att >= 0 && cur == stop_mode && att_s == 24'(stop_att)) begin
        stopped = 1; done = 1;
      end else if (!busy_s) begin
        done = 1;
      end else begin
        if (cur != prev) begin
          if (cur != pattern[idx % 6]) seq_err++;
          if (cur == MODE_INIT) begin
            if (longint'(key_s) != st + n_init * stp) key_err++;
            n_init++;
          end
          if (cur != MODE_IDLE && gap_valid) begin
            if (gap_len != hold_set + 1) gap_err++;
            if (first_gap < 0) first_gap = gap_len;
          end
          idx++;
          if (cur != MODE_IDLE) begin
            if (slow) lat = (cur == MODE_INIT) ? 256 : (cur == MODE_SHUF) ? 768 : 1000;
            else      lat = $urandom_range(0, 5);
          end else begin
            hold_set = (hold_fix >= 0) ? hold_fix : $urandom_range(0, 3);
            hold = hold_set; gap_len = 0; gap_valid = 1;
          end
        end
        if (cur == MODE_IDLE) gap_len++;
        if (cur != MODE_IDLE) begin
          b = int'(cur[4:3]) - 1;
          fb = 3'($urandom);
          fb[b] = 1'b0;
          success = 1'($urandom);
          if (lat == 0) begin
            fb[b] = 1'b1;
            if (b == 2) success = (longint'(key_s) == target);
          end else begin
            lat--;
          end
          finish_bus = fb;
        end else begin
          success = 1'($urandom);
          if (hold > 0) hold--;
          else finish_bus = '0;
        end
        start = ($urandom_range(0, 7) == 0);
        prev = cur;
      end
    end
    start = 1'b0;
    check({tag, "_terminated"}, 32'(done), 32'd1);
    if (!stopped) begin
      finish_bus = '0;
      check({tag, "_found"},     32'(found_s), 32'(exp_found));
      check({tag, "_exhausted"}, 32'(exh_s),   32'(!exp_found));
      check({tag, "_busy"},      32'(busy_s),  32'd0);
      check({tag, "_key"},       32'(key_s),   32'(exp_key));
      check({tag, "_attempts"},  32'(att_s),   32'(exp_att));
      check({tag, "_mode"},      32'(mode_s),  32'(MODE_IDLE));
      check({tag, "_mode_seq"},  32'(seq_err), 32'd0);
      check({tag, "_phases"},    32'(idx),     32'(6 * exp_att));
      check({tag, "_key_walk"},  32'(key_err), 32'd0);
      check({tag, "_gap_len"},   32'(gap_err), 32'd0);
    end
  endtask

  initial begin
    int fg;
    int s;
    longint t;
    reset = 1'b0; start = 1'b0; abort = 1'b0; success = 1'b0;
    finish_bus = '0; sel = 0;
    #12;
    check("rst_mode",   32'(mode0), 32'(MODE_IDLE));
    check("rst_key",    32'(key0),  32'd0);
    check("rst_key1",   32'(key1),  32'h3FFFFE);
    check("rst_att",    32'(att0),  32'd0);
    check("rst_flags",  {29'd0, busy0, fnd0, exh0}, 32'd0);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_hold", 32'(mode0), 32'(MODE_IDLE));

    run_search(0, 0, 1'b1, 0, MODE_IDLE, -1, "first_try", fg);
    run_search(0, 5, 1'b0, -1, MODE_IDLE, -1, "key5", fg);
    run_search(0, 1, 1'b0, 4, MODE_IDLE, -1, "init_gap5", fg);
    check("init_gap5_len", 32'(fg), 32'd5);
    run_search(1, 0, 1'b0, -1, MODE_IDLE, -1, "top_exhaust", fg);
    run_search(2, 2, 1'b0, -1, MODE_IDLE, -1, "step3_exhaust", fg);
    run_search(2, 10, 1'b0, -1, MODE_IDLE, -1, "step3_last", fg);

    for (int i = 0; i < 6; i++) begin
      s = $urandom_range(0, 2);
      case (s)
        0: t = $urandom_range(0, 9);
        1: t = 64'h3FFFFD + $urandom_range(0, 2);
        default: t = $urandom_range(0, 12);
      endcase
      run_search(s, t, 1'b0, -1, MODE_IDLE, -1, $sformatf("rnd%0d", i), fg);
    end

    // Abort mid-shuffle of the second attempt; start in the same cycle loses.
    run_search(0, 1000, 1'b0, -1, MODE_SHUF, 1, "abort_run", fg);
    finish_bus = '0; abort = 1'b1; start = 1'b1;
    @(negedge clk); abort = 1'b0; start = 1'b0;
    check("abort_mode",  32'(mode_s), 32'(MODE_IDLE));
    check("abort_flags", {29'd0, busy_s, found_s, exh_s}, 32'd0);
    check("abort_key",   32'(key_s), 32'd1);
    check("abort_att",   32'(att_s), 32'd1);
    abort = 1'b1; start = 1'b1;
    @(negedge clk); abort = 1'b0; start = 1'b0;
    check("abort_wins",  {25'd0, busy_s, mode_s}, 32'(MODE_IDLE));

    // Reset in the middle of the third decrypt phase releases the RAM at once.
    run_search(0, 1000, 1'b0, -1, MODE_DEC, 2, "rst_run", fg);
    check("rst_pre_mode", 32'(mode_s), 32'(MODE_DEC));
    #2 reset = 1'b0;
    #1;
    check("rst_mid_mode",  32'(mode_s), 32'(MODE_IDLE));
    check("rst_mid_key",   32'(key_s),  32'd0);
    check("rst_mid_att",   32'(att_s),  32'd0);
    check("rst_mid_flags", {29'd0, busy_s, found_s, exh_s}, 32'd0);
    finish_bus = '0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
